// File: rtl/riscv_dm_pkg.sv
// Shared DMI field widths and opcode/status encodings for the debug-module side.
package riscv_dm_pkg;

  localparam int unsigned DMI_ADDR_WIDTH = 7;
  localparam int unsigned DMI_DATA_WIDTH = 32;
  localparam int unsigned DMI_OP_WIDTH   = 2;

  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_NOP      = 2'd0;
  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_READ     = 2'd1;
  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_WRITE    = 2'd2;
  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_RESERVED = 2'd3;

  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_SUCCESS = 2'd0;
  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED  = 2'd2;

endpackage

// File: rtl/riscv_dmi_responder_if.sv
// DMI request/response channel plus the register-access port of the DMI responder.
interface riscv_dmi_responder_if;
  import riscv_dm_pkg::*;

  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [DMI_ADDR_WIDTH-1:0] req_addr_i;
  logic [DMI_DATA_WIDTH-1:0] req_data_i;
  logic [DMI_OP_WIDTH-1:0]   req_op_i;

  logic                      resp_valid_o;
  logic                      resp_ready_i;
  logic [DMI_DATA_WIDTH-1:0] resp_data_o;
  logic [DMI_OP_WIDTH-1:0]   resp_op_o;

  logic                      reg_valid_o;
  logic                      reg_ready_i;
  logic                      reg_we_o;
  logic [DMI_ADDR_WIDTH-1:0] reg_addr_o;
  logic [DMI_DATA_WIDTH-1:0] reg_wdata_o;
  logic [DMI_DATA_WIDTH-1:0] reg_rdata_i;
  logic                      reg_err_i;

  // Responder side
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_op_i,
    output req_ready_o,
    output resp_valid_o, resp_data_o, resp_op_o,
    input  resp_ready_i,
    output reg_valid_o, reg_we_o, reg_addr_o, reg_wdata_o,
    input  reg_ready_i, reg_rdata_i, reg_err_i
  );

  // DTM and register-file side
  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_op_i,
    input  req_ready_o,
    input  resp_valid_o, resp_data_o, resp_op_o,
    output resp_ready_i,
    input  reg_valid_o, reg_we_o, reg_addr_o, reg_wdata_o,
    output reg_ready_i, reg_rdata_i, reg_err_i
  );

endinterface

// File: rtl/riscv_dmi_responder.sv
// DMI responder: turns one DMI request at a time into a bounded register access
// and returns the result with a DMI status code.
module riscv_dmi_responder
  import riscv_dm_pkg::*;
#(
  parameter int unsigned               TIMEOUT_CYCLES = 255,
  parameter logic [DMI_ADDR_WIDTH-1:0] MAX_ADDR       = 7'h7F
) (
  input logic                  clk_i,
  input logic                  rst_i,
  riscv_dmi_responder_if.slave bus
);

  localparam int unsigned     CntW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                    state_q, state_d;
  logic                      req_ready_q;
  logic                      capture;
  logic                      timeout;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [DMI_ADDR_WIDTH-1:0] addr_q;
  logic [DMI_DATA_WIDTH-1:0] wdata_q;
  logic [DMI_OP_WIDTH-1:0]   op_q;
  logic [DMI_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [DMI_OP_WIDTH-1:0]   resp_op_q, resp_op_d;

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_op_d   = resp_op_q;
    capture     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid_i && req_ready_q) begin
          capture     = 1'b1;
          cnt_d       = '0;
          resp_data_d = '0;
          if (bus.req_op_i == DMI_OP_NOP) begin
            state_d   = StResp;
            resp_op_d = RD_OP_SUCCESS;
          end else if (bus.req_op_i == DMI_OP_RESERVED || bus.req_addr_i > MAX_ADDR) begin
            state_d   = StResp;
            resp_op_d = RD_OP_FAILED;
          end else begin
            state_d   = StAccess;
          end
        end
      end
      StAccess: begin
        // A completion in the timeout cycle still counts as a normal completion.
        if (bus.reg_ready_i) begin
          state_d     = StResp;
          resp_op_d   = bus.reg_err_i ? RD_OP_FAILED : RD_OP_SUCCESS;
          resp_data_d = (op_q == DMI_OP_READ && !bus.reg_err_i) ? bus.reg_rdata_i : '0;
        end else if (timeout) begin
          state_d     = StResp;
          resp_op_d   = RD_OP_FAILED;
          resp_data_d = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (bus.resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= DMI_OP_NOP;
      resp_data_q <= '0;
      resp_op_q   <= RD_OP_SUCCESS;
    end else begin
      state_q     <= state_d;
      // Registered so req_ready_o stays low throughout reset.
      req_ready_q <= (state_d == StIdle);
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_op_q   <= resp_op_d;
      if (capture) begin
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_data_i;
        op_q    <= bus.req_op_i;
      end
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.reg_valid_o  = (state_q == StAccess);
  assign bus.reg_we_o     = (op_q == DMI_OP_WRITE);
  assign bus.reg_addr_o   = addr_q;
  assign bus.reg_wdata_o  = wdata_q;
  assign bus.resp_valid_o = (state_q == StResp);
  assign bus.resp_data_o  = resp_data_q;
  assign bus.resp_op_o    = resp_op_q;

endmodule

// File: tb/tb_riscv_dmi_responder.sv
// Directed bench for riscv_dmi_responder with TIMEOUT_CYCLES=4 and MAX_ADDR=0x40.
module tb_riscv_dmi_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  riscv_dmi_responder_if bus ();

  riscv_dmi_responder #(
    .TIMEOUT_CYCLES(4),
    .MAX_ADDR      (7'h40)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          wait_cyc;   // ACCESS cycle index that sees reg_ready_i; -1 = never
    logic [31:0] rdata;
    logic        err;
    int          exp_cycles; // ACCESS cycles with reg_valid_o high
    logic [1:0]  exp_op;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Entered and left at a negedge with the responder idle.
  task automatic do_txn(input vec_t v);
    int n;
    chk("idle_req_ready", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = v.op;
    bus.req_addr_i  = v.addr;
    bus.req_data_i  = v.data;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    n = 0;
    while (bus.reg_valid_o === 1'b1 && n < 20) begin
      if (n == 0) begin
        chk("reg_we", 32'(bus.reg_we_o), 32'(v.op == 2'd2));
        chk("reg_addr", 32'(bus.reg_addr_o), 32'(v.addr));
        chk("reg_wdata", bus.reg_wdata_o, v.data);
        chk("access_req_ready", 32'(bus.req_ready_o), 32'd0);
      end
      bus.reg_ready_i = (n == v.wait_cyc);
      bus.reg_err_i   = v.err;
      bus.reg_rdata_i = v.rdata;
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.reg_ready_i = 1'b0;
    bus.reg_err_i   = 1'b0;
    bus.reg_rdata_i = '0;
    chk("access_cycles", 32'(n), 32'(v.exp_cycles));
    chk("resp_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("resp_op", 32'(bus.resp_op_o), 32'(v.exp_op));
    chk("resp_data", bus.resp_data_o, v.exp_data);
    chk("resp_req_ready", 32'(bus.req_ready_o), 32'd0);
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    chk("post_resp_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("post_resp_valid", 32'(bus.resp_valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op    addr   data          wait rdata         err  cyc op    data
    vecs[0] = '{2'd2, 7'h10, 32'hDEADBEEF, 0,  32'h0,        1'b0, 1, 2'd0, 32'h0};
    vecs[1] = '{2'd1, 7'h11, 32'h0,        3,  32'h12345678, 1'b0, 4, 2'd0, 32'h12345678};
    vecs[2] = '{2'd1, 7'h12, 32'h0,        -1, 32'hFFFFFFFF, 1'b0, 4, 2'd2, 32'h0};
    vecs[3] = '{2'd0, 7'h00, 32'h1111,     0,  32'h0,        1'b0, 0, 2'd0, 32'h0};
    vecs[4] = '{2'd3, 7'h05, 32'h2222,     0,  32'h0,        1'b0, 0, 2'd2, 32'h0};
    vecs[5] = '{2'd1, 7'h41, 32'h0,        0,  32'h0,        1'b0, 0, 2'd2, 32'h0};
    vecs[6] = '{2'd1, 7'h20, 32'h0,        1,  32'hCAFEF00D, 1'b1, 2, 2'd2, 32'h0};
    vecs[7] = '{2'd2, 7'h40, 32'h000055AA, 2,  32'h13579BDF, 1'b0, 3, 2'd0, 32'h0};
    vecs[8] = '{2'd1, 7'h40, 32'h0,        0,  32'h0BADF00D, 1'b0, 1, 2'd0, 32'h0BADF00D};

    rst              = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_data_i   = '0;
    bus.req_op_i     = '0;
    bus.resp_ready_i = 1'b0;
    bus.reg_ready_i  = 1'b0;
    bus.reg_rdata_i  = '0;
    bus.reg_err_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_reg_valid", 32'(bus.reg_valid_o), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_resp_op", 32'(bus.resp_op_o), 32'd0);
    chk("rst_resp_data", bus.resp_data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // Response backpressure with a second request waiting.
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'd1;
    bus.req_addr_i  = 7'h05;
    @(posedge clk);
    @(negedge clk);
    bus.req_op_i    = 2'd0;
    bus.req_addr_i  = 7'h00;
    bus.reg_ready_i = 1'b1;
    bus.reg_rdata_i = 32'hA5A50F0F;
    @(posedge clk);
    @(negedge clk);
    bus.reg_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.reg_rdata_i = $urandom;
      chk("bp_resp_valid", 32'(bus.resp_valid_o), 32'd1);
      chk("bp_resp_data", bus.resp_data_o, 32'hA5A50F0F);
      chk("bp_resp_op", 32'(bus.resp_op_o), 32'd0);
      chk("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    chk("bp_after_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("bp_after_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("bp_nop_resp_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("bp_nop_resp_op", 32'(bus.resp_op_o), 32'd0);
    chk("bp_nop_reg_valid", 32'(bus.reg_valid_o), 32'd0);
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready_i = 1'b0;

    // Reset pulse in the middle of an access.
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'd1;
    bus.req_addr_i  = 7'h22;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("mid_reg_valid", 32'(bus.reg_valid_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_reg_valid", 32'(bus.reg_valid_o), 32'd0);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", 32'(bus.resp_valid_o), 32'd0);
      chk("mid_rst_no_access", 32'(bus.reg_valid_o), 32'd0);
    end
    do_txn(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
